// File: rtl/display_scheduler.sv
// Shared 4-digit seven-segment display controller: arbitrates ownership among four
// services, scans digits with active-low anodes and blinks the owner's edit cursor.
module display_scheduler #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 50000000
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic [3:0]  req_i,
    input  logic [3:0]  done_i,
    input  logic [63:0] num_bus_i,
    input  logic [15:0] cur_time_i,
    input  logic [3:0]  edit_en_i,
    input  logic [7:0]  edit_pos_i,
    output logic [3:0]  an_o,
    output logic [6:0]  seg_o,
    output logic [2:0]  owner_o,
    output logic [3:0]  grant_o
);
    localparam int unsigned RefW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BlkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RefW-1:0] RefMax = RefW'(REFRESH_DIV - 1);
    localparam logic [BlkW-1:0] BlkMax = BlkW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StOwned, StRelease} state_e;

    state_e          state_q, state_d;
    logic [2:0]      owner_q, owner_d;
    logic [3:0]      grant_q, grant_d;
    logic [3:0]      served_q, served_d;
    logic [1:0]      digit_q, digit_d;
    logic [RefW-1:0] refresh_q, refresh_d;
    logic [BlkW-1:0] blink_q, blink_d;
    logic            blink_phase_q, blink_phase_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;

    logic [3:0]  eligible;
    logic [3:0]  served_set;
    logic [1:0]  sel_b;
    logic [1:0]  dig_rev;
    logic [15:0] field;
    logic [3:0]  nibble;
    logic        blank_cursor;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Arbitration and ownership FSM
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        served_set = 4'b0000;
        eligible   = req_i & ~served_q;
        case (state_q)
            StIdle: begin
                if (eligible[3]) begin
                    state_d = StOwned; owner_d = 3'd1; grant_d = 4'b1000;
                end else if (eligible[2]) begin
                    state_d = StOwned; owner_d = 3'd2; grant_d = 4'b0100;
                end else if (eligible[1]) begin
                    state_d = StOwned; owner_d = 3'd3; grant_d = 4'b0010;
                end else if (eligible[0]) begin
                    state_d = StOwned; owner_d = 3'd4; grant_d = 4'b0001;
                end
            end
            StOwned: begin
                if (|(done_i & grant_q)) begin
                    served_set = grant_q;
                    state_d    = StRelease; owner_d = 3'd0; grant_d = 4'b0000;
                end else if (~|(req_i & grant_q)) begin
                    state_d = StRelease; owner_d = 3'd0; grant_d = 4'b0000;
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle; owner_d = 3'd0; grant_d = 4'b0000;
            end
        endcase
        // A done on the same cycle as a req drop still sets the flag once.
        served_d = served_set | (served_q & req_i);
    end

    // Free-running scan and blink timebases
    always_comb begin
        refresh_d     = refresh_q + 1'b1;
        digit_d       = digit_q;
        blink_d       = blink_q + 1'b1;
        blink_phase_d = blink_phase_q;
        if (refresh_q == RefMax) begin
            refresh_d = '0;
            digit_d   = digit_q + 2'd1;
        end
        if (blink_q == BlkMax) begin
            blink_d       = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    // Display source follows the next-state owner so an/seg line up with owner_o.
    always_comb begin
        case (owner_d)
            3'd1:    sel_b = 2'd3;
            3'd2:    sel_b = 2'd2;
            3'd3:    sel_b = 2'd1;
            default: sel_b = 2'd0;
        endcase
        dig_rev      = ~digit_q;
        field        = cur_time_i;
        blank_cursor = 1'b0;
        if (state_d == StOwned) begin
            field        = num_bus_i[{sel_b, 4'b0000} +: 16];
            blank_cursor = edit_en_i[sel_b] && blink_phase_q &&
                           (edit_pos_i[{sel_b, 1'b0} +: 2] == digit_q);
        end
        nibble = field[{dig_rev, 2'b00} +: 4];
        an_d   = ~(4'b1000 >> digit_q);
        seg_d  = blank_cursor ? 7'b0000000 : seg_decode(nibble);
        if (state_d == StRelease) begin
            an_d  = 4'b1111;
            seg_d = 7'b0000000;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q       <= StIdle;
            owner_q       <= 3'd0;
            grant_q       <= 4'b0000;
            served_q      <= 4'b0000;
            digit_q       <= 2'd0;
            refresh_q     <= '0;
            blink_q       <= '0;
            blink_phase_q <= 1'b0;
            an_q          <= 4'b1111;
            seg_q         <= 7'b0000000;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            grant_q       <= grant_d;
            served_q      <= served_d;
            digit_q       <= digit_d;
            refresh_q     <= refresh_d;
            blink_q       <= blink_d;
            blink_phase_q <= blink_phase_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
        end
    end

    assign an_o    = an_q;
    assign seg_o   = seg_q;
    assign owner_o = owner_q;
    assign grant_o = grant_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler: scan, priority, handoff, blink, blank digits, reset.
module tb_display_scheduler;
    logic        clk;
    logic        resetn;
    logic [3:0]  req;
    logic [3:0]  done;
    logic [63:0] num_bus;
    logic [15:0] cur_time;
    logic [3:0]  edit_en;
    logic [7:0]  edit_pos;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [2:0]  owner;
    logic [3:0]  grant;

    int n_cmp;
    int n_fail;

    logic [6:0] seg_tbl [0:9];
    logic [3:0] an_tbl [0:3];
    logic [3:0] blink_digits [0:3];

    display_scheduler #(
        .REFRESH_DIV(4),
        .BLINK_DIV  (16)
    ) dut (
        .clk_i     (clk),
        .resetn_i  (resetn),
        .req_i     (req),
        .done_i    (done),
        .num_bus_i (num_bus),
        .cur_time_i(cur_time),
        .edit_en_i (edit_en),
        .edit_pos_i(edit_pos),
        .an_o      (an),
        .seg_o     (seg),
        .owner_o   (owner),
        .grant_o   (grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [6:0] exp_seg;
        int         d;
        int         ph;
        n_cmp  = 0;
        n_fail = 0;
        seg_tbl[0] = 7'b0111111; seg_tbl[1] = 7'b0000110; seg_tbl[2] = 7'b1011011;
        seg_tbl[3] = 7'b1001111; seg_tbl[4] = 7'b1100110; seg_tbl[5] = 7'b1101101;
        seg_tbl[6] = 7'b1111101; seg_tbl[7] = 7'b0000111; seg_tbl[8] = 7'b1111111;
        seg_tbl[9] = 7'b1101111;
        an_tbl[0] = 4'b0111; an_tbl[1] = 4'b1011; an_tbl[2] = 4'b1101; an_tbl[3] = 4'b1110;
        blink_digits[0] = 4'd5; blink_digits[1] = 4'd9;
        blink_digits[2] = 4'd0; blink_digits[3] = 4'd7;

        // 1: reset values and idle scan of cur_time 12:34
        resetn = 1'b0; req = 4'b0000; done = 4'b0000; num_bus = 64'h0;
        cur_time = 16'h1234; edit_en = 4'b0000; edit_pos = 8'h00;
        #12;
        chk("rst_an", 16'(an), 16'hF);
        chk("rst_seg", 16'(seg), 16'h0);
        chk("rst_owner", 16'(owner), 16'h0);
        chk("rst_grant", 16'(grant), 16'h0);
        @(negedge clk); resetn = 1'b1;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                tick;
                chk("idle_an", 16'(an), 16'(an_tbl[s]));
                chk("idle_seg", 16'(seg), 16'(seg_tbl[s + 1]));
            end
        end
        tick;
        chk("idle_wrap_an", 16'(an), 16'h7);

        // 2: priority, service 2 beats service 4, no preemption by service 1
        resetn = 1'b0; #2;
        @(negedge clk); resetn = 1'b1; req = 4'b0101;
        tick;
        chk("prio_owner", 16'(owner), 16'd2);
        chk("prio_grant", 16'(grant), 16'h4);
        req = 4'b1101;
        tick; tick;
        chk("nopreempt_owner", 16'(owner), 16'd2);
        chk("nopreempt_grant", 16'(grant), 16'h4);

        // 3: release and handoff to service 4
        req = 4'b0101; done = 4'b0100;
        tick;
        done = 4'b0000;
        chk("rel_owner", 16'(owner), 16'd0);
        chk("rel_grant", 16'(grant), 16'h0);
        chk("rel_an", 16'(an), 16'hF);
        chk("rel_seg", 16'(seg), 16'h0);
        tick;
        chk("idle_after_rel_owner", 16'(owner), 16'd0);
        tick;
        chk("handoff_owner", 16'(owner), 16'd4);
        chk("handoff_grant", 16'(grant), 16'h1);
        req = 4'b0100;
        tick;
        chk("reqdrop_rel_owner", 16'(owner), 16'd0);
        tick; tick; tick; tick;
        chk("served_block_owner", 16'(owner), 16'd0);
        req = 4'b0000;
        tick;
        req = 4'b0100;
        tick;
        chk("regrant_owner", 16'(owner), 16'd2);
        chk("regrant_grant", 16'(grant), 16'h4);

        // 4: cursor blink on digit 2 of service 1
        resetn = 1'b0; req = 4'b1000; num_bus = {16'h5907, 48'h0};
        edit_en = 4'b1000; edit_pos = 8'b1000_0000;
        #2;
        @(negedge clk); resetn = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick;
            d  = ((k - 1) / 4) % 4;
            ph = ((k - 1) / 16) % 2;
            exp_seg = (d == 2 && ph == 1) ? 7'b0000000 : seg_tbl[blink_digits[d]];
            chk("blink_seg", 16'(seg), 16'(exp_seg));
            if (k == 1) chk("blink_owner", 16'(owner), 16'd1);
            if (k == 26) chk("blink_an", 16'(an), 16'hD);
        end

        // 5: nibbles A and F blank
        resetn = 1'b0; req = 4'b1000; num_bus = {16'hA0F3, 48'h0};
        edit_en = 4'b0000; edit_pos = 8'h00;
        #2;
        @(negedge clk); resetn = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick;
            if (k == 2)  chk("bcd_d0_blank", 16'(seg), 16'h0);
            if (k == 6)  chk("bcd_d1_zero", 16'(seg), 16'(seg_tbl[0]));
            if (k == 10) chk("bcd_d2_blank", 16'(seg), 16'h0);
            if (k == 14) chk("bcd_d3_three", 16'(seg), 16'(seg_tbl[3]));
        end

        // 6: service 1 finishes, service 2 owns, reset mid-scan clears served flags
        done = 4'b1000;
        tick;
        done = 4'b0000; req = 4'b1100;
        tick; tick;
        chk("pre_rst_owner", 16'(owner), 16'd2);
        tick; tick; tick;
        #2;
        resetn = 1'b0;
        #1;
        chk("async_an", 16'(an), 16'hF);
        chk("async_seg", 16'(seg), 16'h0);
        chk("async_owner", 16'(owner), 16'd0);
        chk("async_grant", 16'(grant), 16'h0);
        @(negedge clk); resetn = 1'b1;
        tick;
        chk("post_rst_owner", 16'(owner), 16'd1);
        chk("post_rst_an0", 16'(an), 16'h7);
        tick; tick; tick;
        chk("post_rst_an3", 16'(an), 16'h7);
        tick;
        chk("post_rst_an4", 16'(an), 16'hB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
